// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } div_state_e;

  localparam int unsigned DefaultWidth = 4;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

endpackage

// File: rtl/seq_restoring_divider_addsub_unit.sv
// Ripple-carry adder/subtractor: sub=1 computes a - b via inverted b and carry-in of 1.
module addsub_unit #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         cout
);

  logic [W:0]   carry;
  logic [W-1:0] b_x;

  assign carry[0] = sub;
  assign b_x      = b ^ {W{sub}};

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign result[i]  = a[i] ^ b_x[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_x[i]) | (a[i] & carry[i]) | (b_x[i] & carry[i]);
  end

  assign cout = carry[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider with start/done handshake.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e       state_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [CntW-1:0]  cnt_q;
  logic             dbz_q;

  // Shifted partial remainder keeps the bit pushed out of R, so the trial
  // subtraction is exact even when 2R+1 exceeds WIDTH bits.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;
  logic           unused_cout;

  assign rem_shift = {r_q, q_q[WIDTH-1]};

  addsub_unit #(
    .W(WIDTH + 1)
  ) u_addsub (
    .a      (rem_shift),
    .b      ({1'b0, d_q}),
    .sub    (ModeSub),
    .result (trial),
    .cout   (unused_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dbz_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            d_q   <= divisor;
            cnt_q <= '0;
            if (divisor != '0) begin
              r_q     <= '0;
              q_q     <= dividend;
              dbz_q   <= 1'b0;
              busy    <= 1'b1;
              state_q <= StRun;
            end else begin
              r_q     <= dividend;
              q_q     <= '1;
              dbz_q   <= 1'b1;
              state_q <= StFin;
            end
          end
        end
        StRun: begin
          // trial[WIDTH] set means the subtraction went negative: restore.
          q_q <= {q_q[WIDTH-2:0], ~trial[WIDTH]};
          if (trial[WIDTH]) begin
            r_q <= rem_shift[WIDTH-1:0];
          end else begin
            r_q <= trial[WIDTH-1:0];
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_q <= StFin;
          end
        end
        StFin: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          quotient    <= q_q;
          remainder   <= r_q;
          div_by_zero <= dbz_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
